// File: rtl/result_deserializer_pkg.sv
// result_deserializer_pkg: shared state encoding and default sizes for the result readout receiver
package result_deserializer_pkg;
  localparam int RES_DATA_W = 18;
  localparam int RES_NUM_WORDS = 32;
  typedef enum logic [2:0] {IDLE, WAIT_FIN, SELECT, STROBE, WAIT_BIT, PUSH, FIN} state_e;
endpackage

// File: rtl/result_deserializer_if.sv
// result_deserializer_if: valid/ready word stream carrying assembled result words
// out_data: assembled word, out_valid: word valid, out_ready: consumer accepts
interface result_deserializer_if #(parameter int DATA_W = result_deserializer_pkg::RES_DATA_W);
  logic [DATA_W-1:0] out_data;
  logic out_valid;
  logic out_ready;
  modport master (output out_data, out_valid, input out_ready);
  modport slave (input out_data, out_valid, output out_ready);
endinterface

// File: rtl/result_deserializer_serial_shift_in.sv
// serial_shift_in: MSB-first shift register, new bit enters at the LSB
// clk/rst: clock and sync reset, clr_i: clear, en_i: sample bit_i, data_o: register contents
module serial_shift_in import result_deserializer_pkg::*; #(
  parameter int DATA_W = RES_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic              bit_i,
  output logic [DATA_W-1:0] data_o
);
  logic [DATA_W-1:0] data_q;
  always_ff @(posedge clk) begin
    if (rst || clr_i) data_q <= '0;
    else if (en_i) data_q <= DATA_W'({data_q, bit_i});
  end
  assign data_o = data_q;
endmodule

// File: rtl/result_deserializer.sv
// result_deserializer: host receiver that strobes the accelerator's serial readout port and emits words
// go_i: start request, finish_i: accelerator complete, cs_n_o/ry_o: select and bit strobe,
// read_data_i: serial bit, busy_o: session active, done_o: session end pulse, bus: word stream
module result_deserializer import result_deserializer_pkg::*; #(
  parameter int DATA_W    = RES_DATA_W,
  parameter int NUM_WORDS = RES_NUM_WORDS,
  parameter int RD_LAT    = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic go_i,
  input  logic finish_i,
  input  logic read_data_i,
  output logic cs_n_o,
  output logic ry_o,
  output logic busy_o,
  output logic done_o,
  result_deserializer_if.master bus
);
  localparam int BW = DATA_W > 1 ? $clog2(DATA_W) : 1;
  localparam int WW = NUM_WORDS > 1 ? $clog2(NUM_WORDS) : 1;
  localparam int LW = $clog2(RD_LAT + 1);
  logic [2:0] state_q, state_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [WW-1:0] word_q, word_d;
  logic [LW-1:0] lat_q, lat_d;
  logic cs_n_q, ry_q, valid_q, busy_q, done_q;
  logic sample, last_bit, last_word, accept;
  // the bit is taken on the last count-down cycle, RD_LAT cycles after the strobe
  assign sample = state_q == WAIT_BIT && lat_q == LW'(1);
  assign last_bit = bit_q == BW'(DATA_W - 1);
  assign last_word = word_q == WW'(NUM_WORDS - 1);
  assign accept = state_q == PUSH && bus.out_ready;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     state_d = go_i ? WAIT_FIN : IDLE;
      WAIT_FIN: state_d = finish_i ? SELECT : WAIT_FIN;
      SELECT:   state_d = STROBE;
      STROBE:   state_d = WAIT_BIT;
      WAIT_BIT: state_d = sample ? (last_bit ? PUSH : STROBE) : WAIT_BIT;
      PUSH:     state_d = bus.out_ready ? (last_word ? FIN : STROBE) : PUSH;
      default:  state_d = IDLE;
    endcase
  end
  assign bit_d = sample ? (last_bit ? '0 : bit_q + 1'b1) : bit_q;
  assign word_d = state_q == FIN ? '0 : (accept && !last_word) ? word_q + 1'b1 : word_q;
  assign lat_d = state_q == STROBE ? LW'(RD_LAT) : state_q == WAIT_BIT ? lat_q - 1'b1 : lat_q;
  // outputs are registered from the next state so they line up with state_q
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bit_q <= '0;
      word_q <= '0;
      lat_q <= '0;
      cs_n_q <= 1'b1;
      ry_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q <= bit_d;
      word_q <= word_d;
      lat_q <= lat_d;
      cs_n_q <= !(state_d inside {SELECT, STROBE, WAIT_BIT, PUSH});
      ry_q <= state_d == STROBE;
      valid_q <= state_d == PUSH;
      busy_q <= state_d != IDLE;
      done_q <= state_d == FIN;
    end
  end
  serial_shift_in #(.DATA_W(DATA_W)) u_shift (
    .clk(clk),
    .rst(rst),
    .clr_i(state_q == FIN),
    .en_i(sample),
    .bit_i(read_data_i),
    .data_o(bus.out_data)
  );
  assign bus.out_valid = valid_q;
  assign cs_n_o = cs_n_q;
  assign ry_o = ry_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
endmodule
